// File: rtl/div_unit.sv
// -----------------------------------------------------------------------------
// div_unit
// Multi-cycle restoring integer divider for the EX stage (DIV / DIVU).
// One quotient bit is resolved per cycle. The result is presented as
// {remainder, quotient} for the HI/LO write. While a division is in flight
// the unit raises a stall request so that ID/EX and earlier stages hold.
//
// Ports
//   clk           clock, all state updates on the rising edge
//   rst           synchronous reset, active low
//   signed_div_i  1 = signed divide (DIV), 0 = unsigned (DIVU)
//   opdata1_i     dividend
//   opdata2_i     divisor
//   start_i       division request, held high until the result is taken
//   annul_i       cancels the in-flight division (flush / exception)
//   result_o      {remainder, quotient}
//   ready_o       result_o is valid
//   stallreq_o    stall request toward pipeline control
// -----------------------------------------------------------------------------
module div_unit #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  signed_div_i,
  input  logic [DATA_W-1:0]     opdata1_i,
  input  logic [DATA_W-1:0]     opdata2_i,
  input  logic                  start_i,
  input  logic                  annul_i,
  output logic [2*DATA_W-1:0]   result_o,
  output logic                  ready_o,
  output logic                  stallreq_o
);

  typedef enum logic [1:0] {
    S_FREE   = 2'd0,
    S_BYZERO = 2'd1,
    S_ON     = 2'd2,
    S_END    = 2'd3
  } state_t;

  localparam logic [DATA_W-1:0] ZERO_D = {DATA_W{1'b0}};
  localparam logic [CNT_W-1:0]  ZERO_C = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]  ONE_C  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]  LAST_C = CNT_W'(DATA_W);

  // Two's-complement negation.
  function automatic logic [DATA_W-1:0] twos_neg(input logic [DATA_W-1:0] v);
    return (~v) + {{(DATA_W-1){1'b0}}, 1'b1};
  endfunction

  state_t                r_state,  w_state_n;
  logic [DATA_W-1:0]     r_quo,    w_quo_n;   // dividend bits shift out, quotient bits shift in
  logic [DATA_W-1:0]     r_rem,    w_rem_n;
  logic [DATA_W-1:0]     r_dvsr,   w_dvsr_n;
  logic [CNT_W-1:0]      r_cnt,    w_cnt_n;
  logic                  r_sign1,  w_sign1_n;
  logic                  r_sign2,  w_sign2_n;
  logic                  r_signed, w_signed_n;
  logic [2*DATA_W-1:0]   r_result, w_result_n;
  logic                  r_ready,  w_ready_n;

  logic [DATA_W:0]       w_partial;
  logic [DATA_W:0]       w_diff;
  logic [DATA_W-1:0]     w_abs1;
  logic [DATA_W-1:0]     w_abs2;
  logic [DATA_W-1:0]     w_quo_fix;
  logic [DATA_W-1:0]     w_rem_fix;

  // Trial subtraction, operand magnitudes and final sign correction.
  always_comb begin
    w_partial = {r_rem, r_quo[DATA_W-1]};
    // The remainder is always below the divisor, so a DATA_W+1 bit
    // difference is wide enough for its MSB to be a reliable sign bit.
    w_diff    = w_partial - {1'b0, r_dvsr};
    w_abs1    = (signed_div_i && opdata1_i[DATA_W-1]) ? twos_neg(opdata1_i) : opdata1_i;
    w_abs2    = (signed_div_i && opdata2_i[DATA_W-1]) ? twos_neg(opdata2_i) : opdata2_i;
    w_quo_fix = (r_signed && (r_sign1 ^ r_sign2)) ? twos_neg(r_quo) : r_quo;
    w_rem_fix = (r_signed && r_sign1) ? twos_neg(r_rem) : r_rem;
  end

  // Next-state, datapath and registered-output selection.
  always_comb begin
    w_state_n  = r_state;
    w_quo_n    = r_quo;
    w_rem_n    = r_rem;
    w_dvsr_n   = r_dvsr;
    w_cnt_n    = r_cnt;
    w_sign1_n  = r_sign1;
    w_sign2_n  = r_sign2;
    w_signed_n = r_signed;
    w_result_n = r_result;
    w_ready_n  = r_ready;
    case (r_state)
      S_FREE: begin
        w_ready_n  = 1'b0;
        w_result_n = {ZERO_D, ZERO_D};
        if (start_i && !annul_i) begin
          if (opdata2_i == ZERO_D) begin
            w_state_n = S_BYZERO;
          end else begin
            w_quo_n    = w_abs1;
            w_dvsr_n   = w_abs2;
            w_rem_n    = ZERO_D;
            w_cnt_n    = ZERO_C;
            w_sign1_n  = opdata1_i[DATA_W-1];
            w_sign2_n  = opdata2_i[DATA_W-1];
            w_signed_n = signed_div_i;
            w_state_n  = S_ON;
          end
        end else begin
          w_state_n = S_FREE;
        end
      end
      S_BYZERO: begin
        w_result_n = {ZERO_D, ZERO_D};
        if (annul_i) begin
          w_ready_n = 1'b0;
          w_state_n = S_FREE;
        end else begin
          w_ready_n = 1'b1;
          w_state_n = S_END;
        end
      end
      S_ON: begin
        if (annul_i) begin
          w_ready_n  = 1'b0;
          w_result_n = {ZERO_D, ZERO_D};
          w_state_n  = S_FREE;
        end else if (r_cnt == LAST_C) begin
          w_ready_n  = 1'b1;
          w_result_n = {w_rem_fix, w_quo_fix};
          w_state_n  = S_END;
        end else begin
          if (!w_diff[DATA_W]) begin
            w_rem_n = w_diff[DATA_W-1:0];
            w_quo_n = {r_quo[DATA_W-2:0], 1'b1};
          end else begin
            w_rem_n = w_partial[DATA_W-1:0];
            w_quo_n = {r_quo[DATA_W-2:0], 1'b0};
          end
          w_cnt_n = r_cnt + ONE_C;
        end
      end
      S_END: begin
        if (start_i) begin
          w_ready_n = 1'b1;
          w_state_n = S_END;
        end else begin
          w_ready_n  = 1'b0;
          w_result_n = {ZERO_D, ZERO_D};
          w_state_n  = S_FREE;
        end
      end
      default: begin
        w_ready_n  = 1'b0;
        w_result_n = {ZERO_D, ZERO_D};
        w_state_n  = S_FREE;
      end
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state  <= S_FREE;
      r_quo    <= ZERO_D;
      r_rem    <= ZERO_D;
      r_dvsr   <= ZERO_D;
      r_cnt    <= ZERO_C;
      r_sign1  <= 1'b0;
      r_sign2  <= 1'b0;
      r_signed <= 1'b0;
      r_result <= {ZERO_D, ZERO_D};
      r_ready  <= 1'b0;
    end else begin
      r_state  <= w_state_n;
      r_quo    <= w_quo_n;
      r_rem    <= w_rem_n;
      r_dvsr   <= w_dvsr_n;
      r_cnt    <= w_cnt_n;
      r_sign1  <= w_sign1_n;
      r_sign2  <= w_sign2_n;
      r_signed <= w_signed_n;
      r_result <= w_result_n;
      r_ready  <= w_ready_n;
    end
  end

  assign result_o   = r_result;
  assign ready_o    = r_ready;
  // Combinational so the pipeline holds in the same cycle start_i appears.
  assign stallreq_o = start_i & ~r_ready & ~annul_i;

endmodule

// File: tb/tb_div_unit.sv
// -----------------------------------------------------------------------------
// tb_div_unit
// Self-checking bench for div_unit: directed cases plus randomized divides
// compared against a plain-arithmetic reference model.
// -----------------------------------------------------------------------------
module tb_div_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        signed_div_i;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic        start_i;
  logic        annul_i;
  logic [63:0] result_o;
  logic        ready_o;
  logic        stallreq_o;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  div_unit #(.DATA_W(32), .CNT_W(6)) dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (signed_div_i),
    .opdata1_i    (opdata1_i),
    .opdata2_i    (opdata2_i),
    .start_i      (start_i),
    .annul_i      (annul_i),
    .result_o     (result_o),
    .ready_o      (ready_o),
    .stallreq_o   (stallreq_o)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Reference: 64-bit arithmetic, C-style truncation, zeros for divide by zero.
  function automatic logic [63:0] ref_div(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    if (b == 32'd0) return 64'd0;
    if (sgn) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'({32'd0, a});
      sb = longint'({32'd0, b});
    end
    q = sa / sb;
    r = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  task automatic run_div(input string tag, input logic sgn, input logic [31:0] a,
                         input logic [31:0] b, input logic [63:0] exp,
                         input int hold, input logic glitch);
    int   lat;
    int   exp_lat;
    logic stall_ok;
    logic done;
    exp_lat = (b == 32'd0) ? 2 : 34;
    @(posedge clk); #1;
    signed_div_i = sgn;
    opdata1_i    = a;
    opdata2_i    = b;
    annul_i      = 1'b0;
    start_i      = 1'b1;
    stall_ok = 1'b1;
    done     = 1'b0;
    lat      = 0;
    for (int c = 1; c <= 100 && !done; c++) begin
      @(negedge clk);
      if (stallreq_o !== 1'b1) stall_ok = 1'b0;
      if (glitch && c == 5) begin
        rst = 1'b0; #1; rst = 1'b1;
      end
      @(posedge clk); #1;
      // operands are only sampled in FREE; scramble them afterwards
      if (c == 1) begin
        opdata1_i = ~a;
        opdata2_i = b + 32'd3;
      end
      if (ready_o === 1'b1) begin
        done = 1'b1;
        lat  = c;
      end
    end
    chk({tag, "_stall"}, {63'd0, stall_ok}, 64'd1);
    chk({tag, "_lat"}, 64'(lat), 64'(exp_lat));
    chk({tag, "_res"}, result_o, exp);
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      chk({tag, "_hold_rdy"}, {63'd0, ready_o}, 64'd1);
      chk({tag, "_hold_res"}, result_o, exp);
    end
    start_i = 1'b0;
    @(posedge clk); #1;
    chk({tag, "_rel_rdy"}, {63'd0, ready_o}, 64'd0);
    chk({tag, "_rel_res"}, result_o, 64'd0);
  endtask

  task automatic watch_no_ready(input string tag, input int n);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      if (ready_o !== 1'b0) seen = 1'b1;
    end
    chk(tag, {63'd0, seen}, 64'd0);
  endtask

  initial begin
    logic        sgn;
    logic [31:0] a;
    logic [31:0] b;
    logic        stall_seen;
    int          sel;

    rst          = 1'b0;
    start_i      = 1'b0;
    annul_i      = 1'b0;
    signed_div_i = 1'b0;
    opdata1_i    = 32'd0;
    opdata2_i    = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_rdy", {63'd0, ready_o}, 64'd0);
    chk("reset_res", result_o, 64'd0);
    chk("reset_stall", {63'd0, stallreq_o}, 64'd0);
    rst = 1'b1;

    // directed cases
    run_div("u100_7",   1'b0, 32'd100,        32'd7,          {32'd2, 32'd14},                0, 1'b0);
    run_div("s_m7_2",   1'b1, 32'hFFFFFFF9,   32'd2,          {32'hFFFFFFFF, 32'hFFFFFFFD},   0, 1'b0);
    run_div("s_7_m2",   1'b1, 32'd7,          32'hFFFFFFFE,   {32'd1, 32'hFFFFFFFD},          0, 1'b0);
    run_div("s_m8_m3",  1'b1, 32'hFFFFFFF8,   32'hFFFFFFFD,   {32'hFFFFFFFE, 32'd2},          0, 1'b0);
    run_div("divzero",  1'b0, 32'd1234,       32'd0,          64'd0,                          0, 1'b0);
    run_div("u_msb",    1'b0, 32'h80000000,   32'hFFFFFFFF,   {32'h80000000, 32'd0},          0, 1'b0);
    run_div("u_big",    1'b0, 32'hFFFFFFFE,   32'h7FFFFFFF,   {32'd0, 32'd2},                 0, 1'b0);
    run_div("glitch",   1'b0, 32'd1000,       32'd3,          {32'd1, 32'd333},               0, 1'b1);
    run_div("s_ovf",    1'b1, 32'h80000000,   32'hFFFFFFFF,   {32'd0, 32'h80000000},          5, 1'b0);

    // annul at iteration 10
    @(posedge clk); #1;
    signed_div_i = 1'b0; opdata1_i = 32'd1000; opdata2_i = 32'd3; start_i = 1'b1;
    repeat (11) @(posedge clk);
    #1;
    annul_i = 1'b1;
    @(negedge clk);
    chk("annul_stall", {63'd0, stallreq_o}, 64'd0);
    @(posedge clk); #1;
    annul_i = 1'b0; start_i = 1'b0;
    watch_no_ready("annul_noready", 40);
    run_div("after_annul", 1'b0, 32'hFFFFFFFF, 32'h10, {32'hF, 32'h0FFFFFFF}, 0, 1'b0);

    // start and annul together: nothing begins
    @(posedge clk); #1;
    opdata1_i = 32'd50; opdata2_i = 32'd5; start_i = 1'b1; annul_i = 1'b1;
    stall_seen = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (stallreq_o !== 1'b0) stall_seen = 1'b1;
    end
    chk("start_annul_stall", {63'd0, stall_seen}, 64'd0);
    @(posedge clk); #1;
    start_i = 1'b0; annul_i = 1'b0;
    watch_no_ready("start_annul_noready", 40);

    // reset at iteration 5
    @(posedge clk); #1;
    opdata1_i = 32'd1000; opdata2_i = 32'd3; start_i = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    rst = 1'b0; start_i = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    chk("rst_on_rdy", {63'd0, ready_o}, 64'd0);
    chk("rst_on_res", result_o, 64'd0);
    watch_no_ready("rst_on_noready", 40);

    // randomized divides against the reference model
    for (int n = 0; n < 24; n++) begin
      sgn = 1'($urandom_range(0, 1));
      a   = $urandom;
      sel = $urandom_range(0, 7);
      case (sel)
        0:       b = 32'd0;
        1:       b = $urandom_range(1, 15);
        2:       b = 32'hFFFFFFFF;
        3:       begin a = 32'h80000000; b = $urandom; end
        default: b = $urandom >> $urandom_range(0, 31);
      endcase
      run_div("rnd", sgn, a, b, ref_div(sgn, a, b), 0, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
